// File: rtl/shift_exec_unit_if.sv
// Issue/writeback channels of the shift execution unit: op request with valid/ready,
// result with valid/ready, plus the pipeline flush.
interface shift_exec_unit_if #(
    parameter int N    = 5,
    parameter int TAGW = 5
);
    localparam int XLEN = 2 ** N;

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [TAGW-1:0] out_tag;

    modport master (
        output flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/shift_exec_unit.sv
// Two-stage shift/rotate unit: stage 1 rewrites every op as a right funnel shift,
// stage 2 runs the funnel shifter and holds the result for writeback.
module funnel_shifter #(
    parameter int N = 5
) (
    input  logic [2**N-1:0] upper,
    input  logic [2**N-1:0] lower,
    input  logic [N-1:0]    amt,
    input  logic            direction,
    output logic [2**N-1:0] result
);
    localparam int XLEN = 2 ** N;

    logic [2*XLEN-1:0] cat;
    assign cat = {upper, lower};

    // Right mode takes the low word of {upper,lower}>>amt, left mode the high word of <<amt.
    generate
        for (genvar gi = 0; gi < XLEN; gi++) begin : g_bit
            logic [N:0] idx_r;
            logic [N:0] idx_l;
            assign idx_r      = (N+1)'(gi) + {1'b0, amt};
            assign idx_l      = (N+1)'(XLEN + gi) - {1'b0, amt};
            assign result[gi] = direction ? cat[idx_l] : cat[idx_r];
        end
    endgenerate
endmodule

module shift_exec_unit #(
    parameter int N    = 5,
    parameter int TAGW = 5
) (
    input  logic             clk,
    input  logic             rst,
    shift_exec_unit_if.slave bus
);
    localparam int XLEN = 2 ** N;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    logic            s1_valid_reg;
    logic [XLEN-1:0] s1_upper_reg;
    logic [XLEN-1:0] s1_lower_reg;
    logic [N-1:0]    s1_amt_reg;
    logic [TAGW-1:0] s1_tag_reg;

    logic            s2_valid_reg;
    logic [XLEN-1:0] out_result_reg;
    logic [TAGW-1:0] out_tag_reg;

    logic            adv1;
    logic            adv2;
    logic            accept;
    logic [N-1:0]    s;
    logic [N-1:0]    s_neg;
    logic            msb;
    logic [XLEN-1:0] upper_next;
    logic [XLEN-1:0] lower_next;
    logic [N-1:0]    amt_next;
    logic [XLEN-1:0] funnel_out;
    logic            unused_b;

    assign unused_b = ^bus.in_b[XLEN-1:N];

    assign adv2   = !s2_valid_reg || bus.out_ready;
    assign adv1   = !s1_valid_reg || adv2;
    assign accept = bus.in_valid && bus.in_ready;

    assign bus.in_ready   = adv1 && !bus.flush;
    assign bus.out_valid  = s2_valid_reg;
    assign bus.out_result = out_result_reg;
    assign bus.out_tag    = out_tag_reg;

    assign s     = bus.in_b[N-1:0];
    assign s_neg = ~s + 1'b1;
    assign msb   = bus.in_a[XLEN-1];

    // Left shifts become right shifts by (XLEN-s) mod XLEN; s=0 is a plain pass-through
    // because that modulo would otherwise select the wrong word for SLL.
    always_comb begin
        upper_next = '0;
        lower_next = '0;
        amt_next   = '0;
        unique case (bus.in_op)
            OP_SLL: begin
                upper_next = bus.in_a;
                amt_next   = s_neg;
            end
            OP_SRL: begin
                lower_next = bus.in_a;
                amt_next   = s;
            end
            OP_SRA: begin
                upper_next = {XLEN{msb}};
                lower_next = bus.in_a;
                amt_next   = s;
            end
            OP_ROL: begin
                upper_next = bus.in_a;
                lower_next = bus.in_a;
                amt_next   = s_neg;
            end
            OP_ROR: begin
                upper_next = bus.in_a;
                lower_next = bus.in_a;
                amt_next   = s;
            end
            default: begin
                upper_next = '0;
                lower_next = '0;
                amt_next   = '0;
            end
        endcase
        if (s == '0 && bus.in_op <= OP_ROR) begin
            upper_next = '0;
            lower_next = bus.in_a;
            amt_next   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_upper_reg <= '0;
            s1_lower_reg <= '0;
            s1_amt_reg   <= '0;
            s1_tag_reg   <= '0;
        end else if (bus.flush) begin
            s1_valid_reg <= 1'b0;
        end else if (adv1) begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_upper_reg <= upper_next;
                s1_lower_reg <= lower_next;
                s1_amt_reg   <= amt_next;
                s1_tag_reg   <= bus.in_tag;
            end
        end
    end

    funnel_shifter #(.N(N)) u_funnel (
        .upper     (s1_upper_reg),
        .lower     (s1_lower_reg),
        .amt       (s1_amt_reg),
        .direction (1'b0),
        .result    (funnel_out)
    );

    // Data registers only move with a real op so a stalled or bubbled output stays put.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_reg   <= 1'b0;
            out_result_reg <= '0;
            out_tag_reg    <= '0;
        end else if (bus.flush) begin
            s2_valid_reg <= 1'b0;
        end else if (adv2) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_result_reg <= funnel_out;
                out_tag_reg    <= s1_tag_reg;
            end
        end
    end
endmodule
